// File: rtl/exec_flags_wb_stage_pkg.sv
// Shared ARM field positions, condition codes and opcodes
// for the execute-to-writeback flags stage.
package exec_flags_wb_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  localparam int COND_MSB = 31;
  localparam int COND_LSB = 28;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 12;
  localparam int OPC_MSB  = 24;
  localparam int OPC_LSB  = 21;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [3:0] {
    OPC_AND = 4'h0,
    OPC_EOR = 4'h1,
    OPC_SUB = 4'h2,
    OPC_RSB = 4'h3,
    OPC_ADD = 4'h4,
    OPC_ADC = 4'h5,
    OPC_SBC = 4'h6,
    OPC_RSC = 4'h7,
    OPC_TST = 4'h8,
    OPC_TEQ = 4'h9,
    OPC_CMP = 4'hA,
    OPC_CMN = 4'hB,
    OPC_ORR = 4'hC,
    OPC_MOV = 4'hD,
    OPC_BIC = 4'hE,
    OPC_MVN = 4'hF
  } opc_e;

  function automatic logic is_compare(
    input logic [3:0] opc
  );
    return opc inside {
      OPC_TST, OPC_TEQ,
      OPC_CMP, OPC_CMN
    };
  endfunction

  function automatic logic is_arith(
    input logic [3:0] opc
  );
    return opc inside {
      OPC_SUB, OPC_RSB,
      OPC_ADD, OPC_ADC,
      OPC_SBC, OPC_RSC,
      OPC_CMP, OPC_CMN
    };
  endfunction

endpackage

// File: rtl/exec_flags_wb_stage_if.sv
// ALU-to-writeback bundle: instruction, result and flags in,
// registered flags and writeback slot out.
interface exec_flags_wb_stage_if
  import exec_flags_wb_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
);
  logic          in_valid;
  logic          stall;
  logic          flush;
  logic [31:0]   inst;
  logic [DW-1:0] alu_out;
  logic          update_CPSR;
  logic          ignore_C_flag;
  logic          N_in;
  logic          Z_in;
  logic          C_in;
  logic          V_in;
  logic [3:0]    cpsr_flags;
  logic          carry_to_alu;
  logic          cond_pass;
  logic          wb_valid;
  logic          wb_en;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  modport master (
    output in_valid, stall, flush,
    output inst, alu_out,
    output update_CPSR, ignore_C_flag,
    output N_in, Z_in, C_in, V_in,
    input  cpsr_flags, carry_to_alu,
    input  cond_pass,
    input  wb_valid, wb_en,
    input  wb_rd, wb_data
  );

  modport slave (
    input  in_valid, stall, flush,
    input  inst, alu_out,
    input  update_CPSR, ignore_C_flag,
    input  N_in, Z_in, C_in, V_in,
    output cpsr_flags, carry_to_alu,
    output cond_pass,
    output wb_valid, wb_en,
    output wb_rd, wb_data
  );
endinterface

// File: rtl/exec_flags_wb_stage_cond_eval.sv
// ARM condition-field evaluator against NZCV flags;
// purely combinational so the branch unit can share it.
module exec_flags_wb_stage_cond_eval
  import exec_flags_wb_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_flags_wb_stage.sv
// Execute-to-writeback stage: owns CPSR NZCV, gates flag
// commit and register writeback on the condition field.
module exec_flags_wb_stage
  import exec_flags_wb_stage_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  exec_flags_wb_stage_if.slave bus
);
  logic [3:0]        cond;
  logic [3:0]        opc;
  logic              accept;
  logic              pass;
  logic              commit;
  logic              cmp_c;
  logic              arith_c;
  logic              keep_c;
  logic              unused_inst;

  logic [3:0]        flags_d;
  logic [3:0]        flags_q;
  logic              wb_valid_d;
  logic              wb_valid_q;
  logic              wb_en_d;
  logic              wb_en_q;
  logic [REG_W-1:0]  wb_rd_d;
  logic [REG_W-1:0]  wb_rd_q;
  logic [DATA_W-1:0] wb_data_d;
  logic [DATA_W-1:0] wb_data_q;

  assign cond = bus.inst[COND_MSB:COND_LSB];
  assign opc  = bus.inst[OPC_MSB:OPC_LSB];

  assign unused_inst = ^{bus.inst[27:25],
                         bus.inst[20:16],
                         bus.inst[11:0]};

  exec_flags_wb_stage_cond_eval u_cond (
    .cond  (cond),
    .flags (flags_q),
    .pass  (pass)
  );

  assign cmp_c   = is_compare(opc);
  assign arith_c = is_arith(opc);
  assign keep_c  = bus.ignore_C_flag
                 && !cmp_c && !arith_c;
  assign accept  = bus.in_valid
                 && !bus.stall && !bus.flush;
  assign commit  = accept && pass
                 && bus.update_CPSR;

  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      flags_d[FLAG_N] = bus.N_in;
      flags_d[FLAG_Z] = bus.Z_in;
      if (!keep_c)
        flags_d[FLAG_C] = bus.C_in;
      if (arith_c)
        flags_d[FLAG_V] = bus.V_in;
    end
  end

  // flush overrides stall so an annulled slot never lingers
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_en_d    = wb_en_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (!bus.stall || bus.flush) begin
      wb_valid_d = accept;
      wb_en_d    = accept && pass && !cmp_c;
    end
    if (!bus.stall) begin
      wb_rd_d   = bus.inst[RD_MSB:RD_LSB];
      wb_data_d = bus.alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= 4'b0000;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.cpsr_flags   = flags_q;
  assign bus.carry_to_alu = flags_q[FLAG_C];
  assign bus.cond_pass    = pass;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;

endmodule

// File: tb/tb_exec_flags_wb_stage.sv
// Directed bench for exec_flags_wb_stage: flag commit,
// condition gating, stall/flush and reset priority.
module tb_exec_flags_wb_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exec_flags_wb_stage_if bus ();

  exec_flags_wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mk(
    input logic [3:0] cond,
    input logic [3:0] opc,
    input logic [3:0] rd
  );
    logic [31:0] w;
    w = 32'h0;
    w[31:28] = cond;
    w[24:21] = opc;
    w[15:12] = rd;
    return w;
  endfunction

  task automatic drive(
    input logic        v,
    input logic        st,
    input logic        fl,
    input logic [31:0] ins,
    input logic [31:0] alu,
    input logic        upd,
    input logic        ign,
    input logic [3:0]  nzcv
  );
    bus.in_valid      = v;
    bus.stall         = st;
    bus.flush         = fl;
    bus.inst          = ins;
    bus.alu_out       = alu;
    bus.update_CPSR   = upd;
    bus.ignore_C_flag = ign;
    bus.N_in          = nzcv[3];
    bus.Z_in          = nzcv[2];
    bus.C_in          = nzcv[1];
    bus.V_in          = nzcv[0];
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset dominates valid, stall and flush
    reset = 1'b1;
    drive(1, 1, 1, mk(4'hE, 4'h4, 4'h9),
          32'hDEAD_BEEF, 1, 0, 4'b1111);
    step();
    chk("rst_flags", 32'(bus.cpsr_flags), 32'h0);
    chk("rst_valid", 32'(bus.wb_valid), 32'h0);
    chk("rst_en", 32'(bus.wb_en), 32'h0);
    chk("rst_rd", 32'(bus.wb_rd), 32'h0);
    chk("rst_data", bus.wb_data, 32'h0);
    chk("rst_carry", 32'(bus.carry_to_alu), 32'h0);

    // ADDS r1: result zero, carry out
    reset = 1'b0;
    drive(1, 0, 0, mk(4'hE, 4'h4, 4'h1),
          32'h0, 1, 0, 4'b0110);
    step();
    chk("adds_flags", 32'(bus.cpsr_flags), 32'h6);
    chk("adds_valid", 32'(bus.wb_valid), 32'h1);
    chk("adds_en", 32'(bus.wb_en), 32'h1);
    chk("adds_rd", 32'(bus.wb_rd), 32'h1);
    chk("adds_data", bus.wb_data, 32'h0);
    chk("adds_carry", 32'(bus.carry_to_alu), 32'h1);

    // MOVS r3, logical with no shifter carry
    drive(1, 0, 0, mk(4'hE, 4'hD, 4'h3),
          32'h8000_0000, 1, 1, 4'b1001);
    step();
    chk("movs_flags", 32'(bus.cpsr_flags), 32'hA);
    chk("movs_en", 32'(bus.wb_en), 32'h1);
    chk("movs_rd", 32'(bus.wb_rd), 32'h3);
    chk("movs_data", bus.wb_data, 32'h8000_0000);

    // ADDS r4 sets Z only
    drive(1, 0, 0, mk(4'hE, 4'h4, 4'h4),
          32'h0, 1, 0, 4'b0100);
    step();
    chk("z_flags", 32'(bus.cpsr_flags), 32'h4);

    // CMP then ADDNE r2 back to back
    drive(1, 0, 0, mk(4'hE, 4'hA, 4'h0),
          32'h1234, 1, 0, 4'b0010);
    #1;
    chk("ne_pre_cmp", 32'(bus.cond_pass), 32'h1);
    step();
    chk("cmp_flags", 32'(bus.cpsr_flags), 32'h2);
    chk("cmp_valid", 32'(bus.wb_valid), 32'h1);
    chk("cmp_en", 32'(bus.wb_en), 32'h0);
    drive(1, 0, 0, mk(4'h1, 4'h4, 4'h2),
          32'h0000_0042, 0, 0, 4'b1111);
    #1;
    chk("addne_pass", 32'(bus.cond_pass), 32'h1);
    step();
    chk("addne_en", 32'(bus.wb_en), 32'h1);
    chk("addne_rd", 32'(bus.wb_rd), 32'h2);
    chk("addne_data", bus.wb_data, 32'h42);
    chk("addne_flags", 32'(bus.cpsr_flags), 32'h2);

    // condition decode against flags 0010
    bus.inst = mk(4'h8, 4'h4, 4'h0);
    #1;
    chk("hi_pass", 32'(bus.cond_pass), 32'h1);
    bus.inst = mk(4'hB, 4'h4, 4'h0);
    #1;
    chk("lt_pass", 32'(bus.cond_pass), 32'h0);
    bus.inst = mk(4'h0, 4'h4, 4'h0);
    #1;
    chk("eq_pass", 32'(bus.cond_pass), 32'h0);

    // NV with update request
    drive(1, 0, 0, mk(4'hF, 4'h4, 4'h5),
          32'h55, 1, 0, 4'b1111);
    #1;
    chk("nv_pass", 32'(bus.cond_pass), 32'h0);
    step();
    chk("nv_valid", 32'(bus.wb_valid), 32'h1);
    chk("nv_en", 32'(bus.wb_en), 32'h0);
    chk("nv_flags", 32'(bus.cpsr_flags), 32'h2);

    // stall for three cycles with shifting inputs
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, mk(4'hE, 4'h4, 4'(7 + i)),
            32'h99 + 32'(i), 1, 0, 4'(4'hF - i));
      step();
      chk("st_valid", 32'(bus.wb_valid), 32'h1);
      chk("st_en", 32'(bus.wb_en), 32'h0);
      chk("st_rd", 32'(bus.wb_rd), 32'h5);
      chk("st_data", bus.wb_data, 32'h55);
      chk("st_flags", 32'(bus.cpsr_flags), 32'h2);
    end

    // flush beats stall
    drive(1, 1, 1, mk(4'hE, 4'h4, 4'h7),
          32'h77, 1, 0, 4'b1111);
    step();
    chk("fs_valid", 32'(bus.wb_valid), 32'h0);
    chk("fs_en", 32'(bus.wb_en), 32'h0);
    chk("fs_flags", 32'(bus.cpsr_flags), 32'h2);

    // EQ fails on Z=0: retires as a no-op
    drive(1, 0, 0, mk(4'h0, 4'h4, 4'h6),
          32'h66, 1, 0, 4'b1111);
    step();
    chk("eqf_valid", 32'(bus.wb_valid), 32'h1);
    chk("eqf_en", 32'(bus.wb_en), 32'h0);
    chk("eqf_flags", 32'(bus.cpsr_flags), 32'h2);

    // plain flush
    drive(1, 0, 1, mk(4'hE, 4'h4, 4'h8),
          32'h88, 1, 0, 4'b1111);
    step();
    chk("fl_valid", 32'(bus.wb_valid), 32'h0);
    chk("fl_flags", 32'(bus.cpsr_flags), 32'h2);

    // SUBS r9: arithmetic takes all four flags
    drive(1, 0, 0, mk(4'hE, 4'h2, 4'h9),
          32'hFFFF_FFFF, 1, 1, 4'b1001);
    step();
    chk("subs_flags", 32'(bus.cpsr_flags), 32'h9);
    chk("subs_carry", 32'(bus.carry_to_alu), 32'h0);

    // reset in the middle of a stall
    reset = 1'b1;
    drive(1, 1, 0, mk(4'hE, 4'h4, 4'hA),
          32'hAA, 1, 0, 4'b1111);
    step();
    chk("rs_flags", 32'(bus.cpsr_flags), 32'h0);
    chk("rs_valid", 32'(bus.wb_valid), 32'h0);
    chk("rs_data", bus.wb_data, 32'h0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_flags_wb_stage.md
Name: exec_flags_wb_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the ALU/shifter block.
- Holds the architectural CPSR flags (NZCV) and evaluates the instruction condition field against them.
- Commits the ALU's flag outputs when permitted, and registers the ALU result and destination register for register-file writeback.
- Feeds the current C flag back to the ALU for ADC/SBC/RSC.

Parameters:
DATA_W, 32, datapath width of ALU result and writeback data
REG_W, 4, register-index width (16 architectural registers)

Ports:
clk  in  1  stage clock; all state updates on rising edge
reset  in  1  synchronous, active-high; takes effect on the clk rising edge
in_valid  in  1  ALU inputs carry a real instruction this cycle
stall  in  1  hold all stage state; upstream keeps inputs stable
flush  in  1  annul the instruction currently presented
inst  in  32  instruction word being executed (ARM encoding)
alu_out  in  DATA_W  ALU result
update_CPSR  in  1  ALU request to write flags
ignore_C_flag  in  1  shifter produced no carry; C must be preserved
N_in, Z_in, C_in, V_in  in  1 each  ALU flag outputs
cpsr_flags  out  4  registered {N,Z,C,V}
carry_to_alu  out  1  equals cpsr_flags[1]
cond_pass  out  1  combinational; condition of inst holds against cpsr_flags
wb_valid  out  1  registered; an instruction occupies the writeback slot
wb_en  out  1  registered; register file must write wb_data to wb_rd
wb_rd  out  REG_W  registered; destination register, inst[15:12]
wb_data  out  DATA_W  registered; ALU result

Behaviour:
- Reset: cpsr_flags=4'b0000; wb_valid=0; wb_en=0; wb_rd=0; wb_data=0. Reset overrides stall, flush and in_valid.
- Define accept = in_valid & ~stall & ~flush.
- Condition, cond = inst[31:28]:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 (NV) 0
  - Evaluated against the registered flags only, so back-to-back dependent instructions see the previous instruction's update with no hazard.
- Opcode class, inst[24:21]:
  - compare class TST/TEQ/CMP/CMN = 1000–1011
  - arithmetic class = 0010–0111, 1010, 1011
  - everything else is logical.
- Flag commit, on the edge when accept & cond_pass & update_CPSR:
  - N<=N_in; Z<=Z_in.
  - C<=C_in, unless ignore_C_flag=1 and the opcode is logical; then C is held.
  - V<=V_in if the opcode is arithmetic; otherwise V is held.
- Writeback register, on every edge with ~stall:
  - wb_valid<=accept.
  - wb_en<=accept & cond_pass & ~compare class.
  - wb_rd<=inst[15:12]; wb_data<=alu_out.
  - wb_rd and wb_data load regardless of accept, but are only meaningful when wb_en=1.
- Latency: one cycle from input presentation to wb_* outputs; flags visible on cpsr_flags the cycle after commit.
- Stall: all registers hold, including flags. flush & stall: flush wins; wb_valid<=0, wb_en<=0, no flag commit.
- Condition fail: wb_valid=1, wb_en=0, flags unchanged (the instruction retires as a no-op).
- Reset mid-stall or mid-flush: reset values apply on that edge; the pending instruction is lost.
- Width rules: REG_W and DATA_W are fixed by the instruction format. No arithmetic in this block.

Decomposition:
- Shared arm_constants additions:
  - condition-code values COND_EQ..COND_NV
  - COND_MSB/COND_LSB (31/28)
  - RD_MSB/RD_LSB (15/12)
  - 4-bit opcode field OPC_MSB/OPC_LSB (24/21) with all 16 data-processing opcode values
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One combinational sub-module, cond_eval (cond[3:0], flags[3:0] -> pass), reused later by the branch unit.

Test Plan:
- Reset with in_valid=1, stall=1, flush=1 -> next cycle cpsr_flags=0000, wb_valid=0, wb_en=0, wb_data=0.
- ADDS r1 (cond AL, opc 0100, update_CPSR=1), alu_out=0, Z_in=1, C_in=1, V_in=0 -> cpsr_flags=0110, wb_en=1, wb_rd=1, wb_data=0.
- Flags=0110; MOVS logical with ignore_C_flag=1, C_in=0, N_in=1, V_in=1 -> cpsr_flags=1010 (C held, V held at 0).
- Flags Z=1, then CMP (opc 1010), then ADDNE r2 in back-to-back cycles -> CMP gives wb_valid=1, wb_en=0, flags=CMP result (Z_in=0). ADDNE then passes on the new Z=0: wb_en=1, wb_rd=2.
- Instruction with cond=1111 and update_CPSR=1 -> wb_valid=1, wb_en=0, cpsr_flags unchanged.
- stall=1 for 3 cycles with varying inputs -> wb_* and cpsr_flags constant. Then flush=1 with stall=1 -> wb_valid=0, flags unchanged.
